demultiplexer1to4_tdm: RTL
==========================

// Module: demultiplexer1to4_tdm
//
// PURPOSE
//  Receive end of the 4:1 time-division link: recovers four lanes from the
//  serial stream driven by multiplexer4to1 when its select is swept 0..3.
//  Tracks the slot with an internal 2-bit counter aligned by frame_sync,
//  assembles the four slot samples and presents them as one registered word.
//  Sits between the link input and the lane consumers; one clock domain.
//
// PARAMETERS
//  WIDTH  1  bits per lane/slot (din width; out is 4*WIDTH)
//
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        synchronous, active-high reset
//  din         in   WIDTH    serial slot data (mux output)
//  din_valid   in   1        din carries a slot sample this cycle
//  frame_sync  in   1        qualifies din as slot 0; sampled only with din_valid
//  out         out  4*WIDTH  assembled word; lane k = out[k*WIDTH +: WIDTH]
//  word_valid  out  1        one-cycle pulse: out updated this cycle
//  s           out  2        current expected slot (mirrors mux select)
//  locked      out  1        1 = frame alignment acquired
//  sync_error  out  1        one-cycle pulse: frame_sync seen at slot != 0
//
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=HUNT; s=0; shadow lanes=0; out=0; word_valid=0;
//   locked=0; sync_error=0. Reset mid-frame discards the partial word.
//  Beat = cycle with din_valid=1. No beat: all state held, pulses low.
//  frame_sync without din_valid: ignored.
//  HUNT (locked=0): beats without frame_sync discarded, s stays 0.
//   Beat with frame_sync: shadow[0]<=din, s<=1, -> LOCKED (locked=1 next cyc).
//  LOCKED (locked=1), beat at slot s:
//   - s in 0..2, no frame_sync (or frame_sync at s==0): shadow[s]<=din,
//     s<=s+1.
//   - s==3, no frame_sync: out<={din,shadow[2],shadow[1],shadow[0]};
//     word_valid=1 in the cycle after the beat; s wraps 3->0.
//   - frame_sync at s!=0: sync_error=1 next cycle; partial word dropped
//     (no word_valid); beat taken as slot 0: shadow[0]<=din, s<=1;
//     stays LOCKED.
//  Latency: slot-3 beat at edge N -> out/word_valid visible after edge N+1
//   (registered); out holds until the next complete word.
//  Back-to-back frames at full rate: word_valid every 4th cycle, no gaps.
//  word_valid and sync_error never both 1 in the same cycle.
//  Shadow lanes internal only; out changes only with word_valid=1.
//
// TESTING
//  1 Reset, then beats with frame_sync=0 -> locked=0, s=0, out=0,
//    word_valid never 1.
//  2 WIDTH=1: frame_sync on first beat, din=1,0,0,0 over 4 beats ->
//    word_valid pulse once, out=4'b0001, s back to 0, locked=1.
//  3 Continuous frames din=0,1,0,0 then 0,0,1,0 then 0,0,0,1 ->
//    out=0010, 0100, 1000 on successive pulses, 4 cycles apart.
//  4 din_valid dropped for 3 cycles after slot 1 -> s holds at 2;
//    frame completes later with correct out, single word_valid.
//  5 frame_sync with beat at s=2 -> sync_error pulse, no word_valid,
//    s=1 next; following 3 beats 1,1,1 after din=0 -> out=4'b1110.
//  6 reset asserted at s=2 -> next cycle s=0, locked=0, out=0;
//    remaining beats of that frame ignored until next frame_sync.

Source files
------------

// File: rtl/demultiplexer1to4_tdm.sv
// Receive side of the 4:1 time-division link: tracks the slot with a 2-bit
// counter aligned by frame_sync and presents each recovered frame as one word.
module demultiplexer1to4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] out,
  output logic               word_valid,
  output logic [1:0]         s,
  output logic               locked,
  output logic               sync_error
);

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  state_t                  state, state_n;
  logic [1:0]              s_n;
  logic [2:0][WIDTH-1:0]   shadow, shadow_n;
  logic [4*WIDTH-1:0]      out_n;
  logic                    word_valid_n;
  logic                    sync_error_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_HUNT;
      s          <= 2'd0;
      shadow     <= '0;
      out        <= '0;
      word_valid <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      state      <= state_n;
      s          <= s_n;
      shadow     <= shadow_n;
      out        <= out_n;
      word_valid <= word_valid_n;
      sync_error <= sync_error_n;
    end
  end

  // Only beats (din_valid) advance anything; pulses default low every cycle.
  always_comb begin
    state_n      = state;
    s_n          = s;
    shadow_n     = shadow;
    out_n        = out;
    word_valid_n = 1'b0;
    sync_error_n = 1'b0;

    if (din_valid) begin
      case (state)
        ST_HUNT: begin
          if (frame_sync) begin
            shadow_n[0] = din;
            s_n         = 2'd1;
            state_n     = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (frame_sync && (s != 2'd0)) begin
            // Misaligned sync: drop the partial word and realign on this beat.
            sync_error_n = 1'b1;
            shadow_n[0]  = din;
            s_n          = 2'd1;
          end else begin
            case (s)
              2'd0: shadow_n[0] = din;
              2'd1: shadow_n[1] = din;
              2'd2: shadow_n[2] = din;
              default: begin
                out_n        = {din, shadow[2], shadow[1], shadow[0]};
                word_valid_n = 1'b1;
              end
            endcase
            s_n = s + 2'd1;
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule
